p2s_frame_sched: RTL and testbench

P2S_FRAME_SCHED -- requirements
Module: p2s_frame_sched

---
 rtl/p2s_frame_sched.sv | 191 +++++++++++++++++++
 tb/tb_p2s_frame_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/p2s_frame_sched.sv
// p2s_frame_sched
//   Arbitrates nibble frames from two requesters and feeds them, one nibble
//   per load strobe, to a parallel-to-serial shifter.
//   A frame is FRAME_LEN nibbles. It is followed by GAP_SLOTS idle load slots.
//
// Ports
//   iclk            clock, all logic on its rising edge
//   irst            synchronous active-low reset
//   ival0/1         requester nibble valid
//   idat0/1 [3:0]   requester nibble (bit 3 is the first serial bit)
//   isop0/1         requester first-nibble-of-frame flag, qualified by ivalN
//   ordy0/1         scheduler accepts the requester nibble this cycle
//   ireq            P2S load strobe (one cycle in four while the P2S runs)
//   odat [3:0]      nibble to the P2S
//   oval            odat valid
//   osop            odat is the first nibble of a frame
//   ogrant [1:0]    one-hot active requester, 00 when none
//   oerr            one-cycle protocol-error pulse
//   ounder          one-cycle underrun pulse (load strobe with nothing held)
//   ostate [1:0]    debug view of the FSM state (0 IDLE, 1 ARB, 2 XFER, 3 GAP)
//
// Handshakes: a requester nibble moves when ivalN & ordyN are both high at a
// rising edge; a held nibble is consumed when ireq & oval are both high at a
// rising edge. Neither side may make its valid depend on the other's ready.

module p2s_frame_sched #(
  parameter int FRAME_LEN = 16,
  parameter int GAP_SLOTS = 2
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic       ival0,
  input  logic       ival1,
  input  logic [3:0] idat0,
  input  logic [3:0] idat1,
  input  logic       isop0,
  input  logic       isop1,
  output logic       ordy0,
  output logic       ordy1,
  input  logic       ireq,
  output logic [3:0] odat,
  output logic       oval,
  output logic       osop,
  output logic [1:0] ogrant,
  output logic       oerr,
  output logic       ounder,
  output logic [1:0] ostate
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] FL     = CW'(FRAME_LEN);
  localparam logic [CW-1:0] FL_M1  = CW'(FRAME_LEN - 1);
  localparam logic [3:0]    GAP_LAST = 4'(GAP_SLOTS - 1);
  localparam bit            HAS_GAP  = (GAP_SLOTS > 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [3:0]    hold_dat;
  logic          hold_vld;
  logic          hold_first;
  logic [CW-1:0] fetch_cnt;
  logic [CW-1:0] sent_cnt;
  logic [3:0]    gap_cnt;
  logic          gsel;        // 0 = requester 0 granted, 1 = requester 1
  logic          last_grant;  // requester of the last completed frame
  logic          err_q;
  logic          under_q;

  // combinational strobes
  logic       sop0, sop1;
  logic       g_val, g_sop;
  logic [3:0] g_dat;
  logic       fetch_ok, consume;
  logic       rdy0, rdy1, accept, drop, under, frame_done, pick;

  assign sop0  = ival0 & isop0;
  assign sop1  = ival1 & isop1;
  assign g_val = gsel ? ival1 : ival0;
  assign g_sop = gsel ? isop1 : isop0;
  assign g_dat = gsel ? idat1 : idat0;

  // Room in the holding register: empty, or being emptied by this load strobe.
  assign fetch_ok = (fetch_cnt < FL) & (~hold_vld | ireq);
  assign consume  = (state == XFER) & ireq & hold_vld;

  always_ff @(posedge iclk) begin
    if (!irst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rdy0       = 1'b0;
    rdy1       = 1'b0;
    accept     = 1'b0;
    drop       = 1'b0;
    under      = 1'b0;
    frame_done = 1'b0;
    pick       = gsel;
    case (state)
      IDLE: begin
        // Stray mid-frame nibbles are drained so a stuck source cannot block.
        rdy0 = ival0 & ~isop0;
        rdy1 = ival1 & ~isop1;
        drop = rdy0 | rdy1;
        if (sop0 | sop1) state_nxt = ARB;
      end
      ARB: begin
        if (sop0 & sop1) pick = ~last_grant;
        else             pick = sop1;
        // A requester that withdrew its SOP leaves nothing to grant.
        state_nxt = (sop0 | sop1) ? XFER : IDLE;
      end
      XFER: begin
        rdy0   = ~gsel & fetch_ok;
        rdy1   =  gsel & fetch_ok;
        accept = g_val & fetch_ok;
        under  = ireq & ~hold_vld;
        if (consume && (sent_cnt == FL_M1)) begin
          frame_done = 1'b1;
          state_nxt  = HAS_GAP ? GAP : IDLE;
        end
      end
      GAP: begin
        if (ireq && (gap_cnt == GAP_LAST)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (!irst) begin
      hold_dat   <= 4'd0;
      hold_vld   <= 1'b0;
      hold_first <= 1'b0;
      fetch_cnt  <= '0;
      sent_cnt   <= '0;
      gap_cnt    <= 4'd0;
      gsel       <= 1'b0;
      last_grant <= 1'b1;
      err_q      <= 1'b0;
      under_q    <= 1'b0;
    end else begin
      // Protocol errors: a drained stray nibble, or a repeated SOP mid-frame.
      err_q   <= drop | (accept & g_sop & (fetch_cnt != '0));
      under_q <= under;

      if (state == ARB) begin
        gsel       <= pick;
        fetch_cnt  <= '0;
        sent_cnt   <= '0;
        hold_vld   <= 1'b0;
        hold_first <= 1'b0;
      end

      if (accept) begin
        hold_dat   <= g_dat;
        hold_vld   <= 1'b1;
        hold_first <= (fetch_cnt == '0);
        fetch_cnt  <= fetch_cnt + 1'b1;
      end else if (consume) begin
        hold_vld <= 1'b0;
      end

      if (consume)    sent_cnt   <= sent_cnt + 1'b1;
      if (frame_done) last_grant <= gsel;

      if (state != GAP) gap_cnt <= 4'd0;
      else if (ireq)    gap_cnt <= gap_cnt + 1'b1;
    end
  end

  // Outputs are forced low while reset is held.
  assign ordy0  = irst & rdy0;
  assign ordy1  = irst & rdy1;
  assign odat   = irst ? hold_dat : 4'd0;
  assign oval   = irst & hold_vld;
  assign osop   = irst & hold_vld & hold_first;
  assign ogrant = (irst && (state == XFER)) ? {gsel, ~gsel} : 2'b00;
  assign oerr   = irst & err_q;
  assign ounder = irst & under_q;
  assign ostate = state;

endmodule

// File: tb/tb_p2s_frame_sched.sv
// tb_p2s_frame_sched
//   Directed bench for p2s_frame_sched with FRAME_LEN=4, GAP_SLOTS=2.
//   Two queue-backed requester drivers feed nibbles; every P2S consumption is
//   checked against an expected queue of {ogrant, osop, odat}.

module tb_p2s_frame_sched;

  localparam int W = 7;

  logic       iclk = 1'b0;
  logic       irst;
  logic       ival0, ival1, isop0, isop1, ireq;
  logic [3:0] idat0, idat1;
  logic       ordy0, ordy1, oval, osop, oerr, ounder;
  logic [3:0] odat;
  logic [1:0] ogrant, ostate;

  p2s_frame_sched #(.FRAME_LEN(4), .GAP_SLOTS(2)) dut (
    .iclk(iclk), .irst(irst),
    .ival0(ival0), .ival1(ival1), .idat0(idat0), .idat1(idat1),
    .isop0(isop0), .isop1(isop1), .ordy0(ordy0), .ordy1(ordy1),
    .ireq(ireq), .odat(odat), .oval(oval), .osop(osop),
    .ogrant(ogrant), .oerr(oerr), .ounder(ounder), .ostate(ostate)
  );

  // ---------------- clock ----------------
  always #5 iclk = ~iclk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];      // {ogrant, osop, odat}
  logic [4:0]   src0[$];       // {isop, idat}
  logic [4:0]   src1[$];
  int n_chk = 0, n_fail = 0;
  int n_err, n_und, cons, pops0, pause_at0, pause0, ph;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive();
    ireq = ((ph % 4) == 3);
    ph++;
    if (pause0 > 0) begin
      ival0 = 1'b0; isop0 = 1'b0; idat0 = 4'd0;
      pause0--;
    end else if (src0.size() > 0) begin
      ival0 = 1'b1; isop0 = src0[0][4]; idat0 = src0[0][3:0];
    end else begin
      ival0 = 1'b0; isop0 = 1'b0; idat0 = 4'($urandom_range(0, 15));
    end
    if (src1.size() > 0) begin
      ival1 = 1'b1; isop1 = src1[0][4]; idat1 = src1[0][3:0];
    end else begin
      ival1 = 1'b0; isop1 = 1'b0; idat1 = 4'($urandom_range(0, 15));
    end
  endtask

  // One clock: monitor at the falling edge, drive just after the rising edge.
  task automatic tick();
    logic [W-1:0] e;
    @(negedge iclk);
    if (ireq && oval) begin
      cons++;
      if (exp_q.size() == 0) begin
        chk("extra_consume", 32'(oval), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("odat",   32'(odat),   32'(e[3:0]));
        chk("osop",   32'(osop),   32'(e[4]));
        chk("ogrant", 32'(ogrant), 32'(e[6:5]));
      end
    end
    if (oerr)   n_err++;
    if (ounder) n_und++;
    if (ival0 && ordy0) begin
      void'(src0.pop_front());
      pops0++;
      if (pops0 == pause_at0) pause0 = 8;
    end
    if (ival1 && ordy1) void'(src1.pop_front());
    @(posedge iclk);
    #1 drive();
    #1;
  endtask

  // nib holds nibble 0 in [15:12]; sop_mask bit 3 belongs to nibble 0.
  task automatic push_frame(input int r, input logic [15:0] nib, input logic [3:0] sop_mask);
    logic [3:0] d;
    for (int i = 0; i < 4; i++) begin
      d = nib[15-4*i -: 4];
      if (r == 0) src0.push_back({sop_mask[3-i], d});
      else        src1.push_back({sop_mask[3-i], d});
      exp_q.push_back({(r == 0) ? 2'b01 : 2'b10, (i == 0), d});
    end
  endtask

  task automatic start_test();
    n_err = 0; n_und = 0; cons = 0; pops0 = 0; pause_at0 = 0; pause0 = 0; ph = 0;
  endtask

  task automatic run_until_empty(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget && ostate != 2'd0; i++) tick();
    chk(tag, 32'(ostate), 32'd0);
  endtask

  task automatic do_reset();
    irst = 1'b0; ival0 = 1'b0; ival1 = 1'b0; ireq = 1'b0;
    src0.delete(); src1.delete(); exp_q.delete();
    repeat (2) @(posedge iclk);
    #1 irst = 1'b1;
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int gap_ticks;
    irst = 1'b0; ireq = 1'b0;
    ival0 = 1'b1; isop0 = 1'b1; idat0 = 4'h5;
    ival1 = 1'b1; isop1 = 1'b0; idat1 = 4'h6;
    start_test();

    // Reset: outputs held at zero while irst is low.
    @(negedge iclk);
    chk("rst_ordy",   32'({ordy0, ordy1}), 32'd0);
    chk("rst_outs",   32'({odat, oval, osop, ogrant, oerr, ounder}), 32'd0);
    @(negedge iclk);
    chk("rst_state",  32'(ostate), 32'd0);
    chk("rst_ordy1",  32'(ordy1), 32'd0);
    do_reset();

    // Single frame on requester 0, latency and gap.
    start_test();
    push_frame(0, 16'hABCD, 4'b1000);
    drive(); #1;
    tick(); chk("t1_arb", 32'(ostate), 32'd1);
    chk("t1_arb_grant", 32'(ogrant), 32'd0);
    tick(); chk("t1_xfer", 32'(ostate), 32'd2);
    chk("t1_ordy", 32'(ordy0), 32'd1);
    tick(); chk("t1_oval_osop", 32'({oval, osop}), 32'b11);
    chk("t1_grant", 32'(ogrant), 32'b01);
    run_until_empty("t1_drain", 100);
    chk("t1_gap_state", 32'(ostate), 32'd3);
    chk("t1_gap_quiet", 32'({oval, ogrant, ordy0}), 32'd0);
    gap_ticks = 0;
    for (int i = 0; i < 50 && ostate != 2'd0; i++) begin tick(); gap_ticks++; end
    chk("t1_gap_len", 32'(gap_ticks), 32'd8);
    chk("t1_cons", 32'(cons), 32'd4);
    chk("t1_err", 32'(n_err), 32'd0);
    chk("t1_under", 32'(n_und), 32'd0);

    // Both requesters tie back-to-back: grants alternate 01,10,01,10.
    do_reset();
    start_test();
    push_frame(0, 16'h1234, 4'b1000);
    push_frame(1, 16'h9ABC, 4'b1000);
    push_frame(0, 16'h5678, 4'b1000);
    push_frame(1, 16'hDEF0, 4'b1000);
    // exp_q must follow grant order, not push order.
    exp_q.delete();
    push_frame(0, 16'h1234, 4'b1000); src0.delete();
    push_frame(1, 16'h9ABC, 4'b1000); src1.delete();
    push_frame(0, 16'h5678, 4'b1000);
    push_frame(1, 16'hDEF0, 4'b1000);
    src0.delete(); src1.delete();
    for (int i = 0; i < 2; i++) begin
      src0.push_back({1'b1, (i == 0) ? 4'h1 : 4'h5});
      src0.push_back({1'b0, (i == 0) ? 4'h2 : 4'h6});
      src0.push_back({1'b0, (i == 0) ? 4'h3 : 4'h7});
      src0.push_back({1'b0, (i == 0) ? 4'h4 : 4'h8});
      src1.push_back({1'b1, (i == 0) ? 4'h9 : 4'hD});
      src1.push_back({1'b0, (i == 0) ? 4'hA : 4'hE});
      src1.push_back({1'b0, (i == 0) ? 4'hB : 4'hF});
      src1.push_back({1'b0, (i == 0) ? 4'hC : 4'h0});
    end
    drive(); #1;
    run_until_empty("t2_drain", 400);
    wait_idle("t2_idle", 50);
    chk("t2_cons", 32'(cons), 32'd16);
    chk("t2_err", 32'(n_err), 32'd0);
    chk("t2_under", 32'(n_und), 32'd0);

    // Requester 0 stalls for 8 cycles after nibble 2: one missed load strobe.
    start_test();
    pause_at0 = 2;
    push_frame(0, 16'h2468, 4'b1000);
    drive(); #1;
    run_until_empty("t3_drain", 200);
    wait_idle("t3_idle", 50);
    chk("t3_cons", 32'(cons), 32'd4);
    chk("t3_under", 32'(n_und), 32'd1);
    chk("t3_err", 32'(n_err), 32'd0);

    // Three stray nibbles on requester 1 in IDLE, then a proper frame.
    start_test();
    src1.push_back({1'b0, 4'h7});
    src1.push_back({1'b0, 4'h8});
    src1.push_back({1'b0, 4'h9});
    push_frame(1, 16'h3C5A, 4'b1000);
    drive(); #1;
    run_until_empty("t4_drain", 200);
    wait_idle("t4_idle", 50);
    chk("t4_err", 32'(n_err), 32'd3);
    chk("t4_cons", 32'(cons), 32'd4);
    chk("t4_under", 32'(n_und), 32'd0);

    // Repeated SOP on nibble 3 is forwarded as data with one error pulse.
    start_test();
    push_frame(0, 16'hF1E2, 4'b1010);
    drive(); #1;
    run_until_empty("t5_drain", 200);
    wait_idle("t5_idle", 50);
    chk("t5_err", 32'(n_err), 32'd1);
    chk("t5_cons", 32'(cons), 32'd4);

    // Reset for one cycle after the 2nd nibble is consumed.
    start_test();
    push_frame(0, 16'h4321, 4'b1000);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    drive(); #1;
    for (int i = 0; i < 100 && cons < 2; i++) tick();
    chk("t6_two_consumed", 32'(cons), 32'd2);
    irst = 1'b0; ireq = 1'b0; ival0 = 1'b0; isop0 = 1'b0;
    src0.delete();
    @(negedge iclk);
    chk("t6_rst_ordy", 32'({ordy0, ordy1}), 32'd0);
    chk("t6_rst_outs", 32'({odat, oval, osop, ogrant, oerr, ounder}), 32'd0);
    @(posedge iclk);
    #1 irst = 1'b1;
    start_test();
    push_frame(0, 16'h8ACE, 4'b1000);
    push_frame(1, 16'h1357, 4'b1000);
    drive(); #1;
    @(negedge iclk);
    chk("t6_post_outs", 32'({odat, oval, osop, ogrant, oerr, ounder, ordy0, ordy1}), 32'd0);
    chk("t6_post_state", 32'(ostate), 32'd0);
    @(posedge iclk);
    #1 drive();
    #1;
    run_until_empty("t6_drain", 300);
    wait_idle("t6_idle", 50);
    chk("t6_err", 32'(n_err), 32'd0);
    chk("t6_under", 32'(n_und), 32'd0);
    chk("t6_cons", 32'(cons), 32'd8);

    $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
    $finish;
  end

endmodule
